// File: rtl/game_types.sv
// Shared board and fleet definitions for the placement phase.
package game_types;

  typedef enum logic [2:0] {
    EMPTY = 3'd0,
    SHIP  = 3'd1,
    HIT   = 3'd2,
    MISS  = 3'd3
  } cell_t;

  // Indexed board[y][x]; sized for the largest supported 16x16 grid.
  typedef logic [15:0][15:0][2:0] board_t;

  localparam logic [0:4][3:0] SHIP_LENGTHS = {4'd5, 4'd4, 4'd3, 4'd3, 4'd2};

  typedef enum logic [2:0] {
    IDLE, CLEAR, AIM, CHECK, WRITE, NEXT, DONE
  } placement_state_t;

  typedef enum logic [2:0] {
    REQ_NONE, REQ_UP, REQ_DOWN, REQ_LEFT, REQ_RIGHT, REQ_ROTATE
  } cursor_req_t;

  function automatic logic [3:0] ship_length(input logic [2:0] idx);
    return (idx < 3'd5) ? SHIP_LENGTHS[idx] : 4'd0;
  endfunction

endpackage

// File: rtl/cursor_clamp.sv
// Next legal preview cursor for one move or rotate request.
module cursor_clamp
  import game_types::*;
#(
  parameter int GRID_ROWS = 10,
  parameter int GRID_COLS = 10
) (
  input  logic [3:0]  x,
  input  logic [3:0]  y,
  input  logic [3:0]  len,
  input  logic        orientation,
  input  cursor_req_t req,
  output logic [3:0]  next_x,
  output logic [3:0]  next_y,
  output logic        next_orientation
);

  logic [4:0] max_x;
  logic [4:0] max_y;
  logic [4:0] mx;
  logic [4:0] my;

  always_comb begin
    next_orientation = (req == REQ_ROTATE) ? ~orientation : orientation;
    // Limits follow the orientation after a rotate so the ship stays on the board.
    max_x = next_orientation ? 5'(GRID_COLS - 1) : 5'(GRID_COLS) - {1'b0, len};
    max_y = next_orientation ? 5'(GRID_ROWS) - {1'b0, len} : 5'(GRID_ROWS - 1);
    mx = {1'b0, x};
    my = {1'b0, y};
    case (req)
      REQ_UP:    if (my != 5'd0) my = my - 5'd1;
      REQ_DOWN:  my = my + 5'd1;
      REQ_LEFT:  if (mx != 5'd0) mx = mx - 5'd1;
      REQ_RIGHT: mx = mx + 5'd1;
      default:   ;
    endcase
    if (mx > max_x) mx = max_x;
    if (my > max_y) my = max_y;
    next_x = mx[3:0];
    next_y = my[3:0];
  end

endmodule

// File: rtl/ship_placement_ctrl.sv
// Placement-phase sequencer: clears the board, aims, overlap-checks and writes each ship.
module ship_placement_ctrl
  import game_types::*;
#(
  parameter int GRID_ROWS = 10,
  parameter int GRID_COLS = 10,
  parameter int NUM_SHIPS = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_rotate,
  input  logic       btn_place,
  input  board_t     board,
  output logic       wr_en,
  output logic [3:0] wr_x,
  output logic [3:0] wr_y,
  output logic [2:0] wr_cell,
  output logic [3:0] cursor_x,
  output logic [3:0] cursor_y,
  output logic [3:0] current_ship_length,
  output logic       current_orientation,
  output logic [2:0] ship_idx,
  output logic       reject,
  output logic       busy,
  output logic       done
);

  placement_state_t state;
  cursor_req_t      req;
  logic [3:0]       k;
  logic [3:0]       len;
  logic [3:0]       cell_x;
  logic [3:0]       cell_y;
  logic [3:0]       nx;
  logic [3:0]       ny;
  logic             norient;

  assign len = ship_length(ship_idx);

  always_comb begin
    req = REQ_NONE;
    if (btn_rotate)     req = REQ_ROTATE;
    else if (btn_up)    req = REQ_UP;
    else if (btn_down)  req = REQ_DOWN;
    else if (btn_left)  req = REQ_LEFT;
    else if (btn_right) req = REQ_RIGHT;
  end

  always_comb begin
    cell_x = current_orientation ? cursor_x : cursor_x + k;
    cell_y = current_orientation ? cursor_y + k : cursor_y;
  end

  cursor_clamp #(
    .GRID_ROWS(GRID_ROWS),
    .GRID_COLS(GRID_COLS)
  ) u_clamp (
    .x               (cursor_x),
    .y               (cursor_y),
    .len             (len),
    .orientation     (current_orientation),
    .req             (req),
    .next_x          (nx),
    .next_y          (ny),
    .next_orientation(norient)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state               <= IDLE;
      k                   <= 4'd0;
      wr_en               <= 1'b0;
      wr_x                <= 4'd0;
      wr_y                <= 4'd0;
      wr_cell             <= 3'd0;
      cursor_x            <= 4'd0;
      cursor_y            <= 4'd0;
      current_ship_length <= 4'd0;
      current_orientation <= 1'b0;
      ship_idx            <= 3'd0;
      reject              <= 1'b0;
      busy                <= 1'b0;
      done                <= 1'b0;
    end else begin
      reject <= 1'b0;
      case (state)
        IDLE, DONE, AIM: begin
          if (start) begin
            state               <= CLEAR;
            wr_en               <= 1'b1;
            wr_x                <= 4'd0;
            wr_y                <= 4'd0;
            wr_cell             <= EMPTY;
            busy                <= 1'b1;
            done                <= 1'b0;
            current_ship_length <= 4'd0;
          end else if (state == AIM) begin
            if (btn_place) begin
              state <= CHECK;
              k     <= 4'd0;
              busy  <= 1'b1;
            end else begin
              cursor_x            <= nx;
              cursor_y            <= ny;
              current_orientation <= norient;
            end
          end
        end
        CLEAR: begin
          if (wr_x == 4'(GRID_COLS - 1) && wr_y == 4'(GRID_ROWS - 1)) begin
            state               <= AIM;
            wr_en               <= 1'b0;
            busy                <= 1'b0;
            ship_idx            <= 3'd0;
            cursor_x            <= 4'd0;
            cursor_y            <= 4'd0;
            current_orientation <= 1'b0;
            current_ship_length <= ship_length(3'd0);
          end else if (wr_x == 4'(GRID_COLS - 1)) begin
            wr_x <= 4'd0;
            wr_y <= wr_y + 4'd1;
          end else begin
            wr_x <= wr_x + 4'd1;
          end
        end
        CHECK: begin
          if (board[cell_y][cell_x] != EMPTY) begin
            state  <= AIM;
            reject <= 1'b1;
            busy   <= 1'b0;
          end else if (k == len - 4'd1) begin
            // Whole footprint is free: present the first write straight away.
            state               <= WRITE;
            k                   <= 4'd0;
            wr_en               <= 1'b1;
            wr_x                <= cursor_x;
            wr_y                <= cursor_y;
            wr_cell             <= SHIP;
            current_ship_length <= 4'd0;
          end else begin
            k <= k + 4'd1;
          end
        end
        WRITE: begin
          if (k == len - 4'd1) begin
            state <= NEXT;
            wr_en <= 1'b0;
            busy  <= 1'b0;
          end else begin
            k <= k + 4'd1;
            if (current_orientation) wr_y <= wr_y + 4'd1;
            else                     wr_x <= wr_x + 4'd1;
          end
        end
        NEXT: begin
          if (ship_idx == 3'(NUM_SHIPS - 1)) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state               <= AIM;
            ship_idx            <= ship_idx + 3'd1;
            cursor_x            <= 4'd0;
            cursor_y            <= 4'd0;
            current_orientation <= 1'b0;
            current_ship_length <= ship_length(ship_idx + 3'd1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ship_placement_ctrl.sv
// Directed bench for ship_placement_ctrl with a behavioural board owner.
module tb_ship_placement_ctrl;
  import game_types::*;

  logic       clk = 1'b0;
  logic       reset, start;
  logic       btn_up, btn_down, btn_left, btn_right, btn_rotate, btn_place;
  board_t     board_m;
  logic       wr_en;
  logic [3:0] wr_x, wr_y;
  logic [2:0] wr_cell;
  logic [3:0] cursor_x, cursor_y, current_ship_length;
  logic       current_orientation;
  logic [2:0] ship_idx;
  logic       reject, busy, done;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ship_placement_ctrl #(.GRID_ROWS(10), .GRID_COLS(10), .NUM_SHIPS(5)) dut (
    .clk(clk), .reset(reset), .start(start),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .btn_rotate(btn_rotate), .btn_place(btn_place), .board(board_m),
    .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_cell(wr_cell),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .current_ship_length(current_ship_length),
    .current_orientation(current_orientation), .ship_idx(ship_idx),
    .reject(reject), .busy(busy), .done(done)
  );

  // Board owner: a write strobed in one cycle is visible from the next.
  always @(posedge clk) begin
    if (reset) board_m <= '0;
    else if (wr_en) board_m[wr_y][wr_x] <= wr_cell;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_btns();
    {start, btn_up, btn_down, btn_left, btn_right, btn_rotate, btn_place} = 7'b0;
  endtask

  // 0 up, 1 down, 2 left, 3 right, 4 rotate, 5 place, 6 start
  task automatic press(input int b, input int n);
    for (int i = 0; i < n; i++) begin
      case (b)
        0: btn_up = 1'b1;
        1: btn_down = 1'b1;
        2: btn_left = 1'b1;
        3: btn_right = 1'b1;
        4: btn_rotate = 1'b1;
        5: btn_place = 1'b1;
        default: start = 1'b1;
      endcase
      step();
      clear_btns();
    end
  endtask

  task automatic do_place(input int x, input int y, input bit vert,
                          output int lat, output int nwr, output int werr);
    if (vert) press(4, 1);
    press(3, x);
    press(1, y);
    press(5, 1);
    lat = 0;
    while (wr_en !== 1'b1 && lat < 40) begin step(); lat++; end
    nwr = 0;
    werr = 0;
    while (wr_en === 1'b1 && nwr < 40) begin
      if (wr_x !== 4'(vert ? x : x + nwr) || wr_y !== 4'(vert ? y + nwr : y) || wr_cell !== 3'(SHIP))
        werr++;
      nwr++;
      step();
    end
    step();
  endtask

  task automatic test_reset();
    clear_btns();
    reset = 1'b1;
    step(); step();
    tests++;
    if ({wr_en, wr_x, wr_y, wr_cell, cursor_x, cursor_y, current_ship_length,
         current_orientation, ship_idx, reject, busy, done} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got wr_en=%0d cur=(%0d,%0d) len=%0d busy=%0d done=%0d, required all 0",
               wr_en, cursor_x, cursor_y, current_ship_length, busy, done);
    end
    reset = 1'b0;
    press(3, 2);
    tests++;
    if (cursor_x !== 4'd0 || busy !== 1'b0 || wr_en !== 1'b0) begin
      fails++;
      $display("FAIL idle_ignores_buttons: got x=%0d busy=%0d wr_en=%0d, required 0 0 0", cursor_x, busy, wr_en);
    end
  endtask

  task automatic test_clear();
    int n = 0;
    int bad = 0;
    press(6, 1);
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL clear_busy: got %0d required 1", busy);
    end
    while (wr_en === 1'b1 && n < 200) begin
      if (wr_x !== 4'(n % 10) || wr_y !== 4'(n / 10) || wr_cell !== 3'(EMPTY)) bad++;
      n++;
      step();
    end
    tests++;
    if (n != 100) begin
      fails++;
      $display("FAIL clear_count: got %0d wr_en cycles required 100", n);
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL clear_order: got %0d bad writes required 0", bad);
    end
    tests++;
    if (current_ship_length !== 4'd5 || ship_idx !== 3'd0 || busy !== 1'b0 ||
        cursor_x !== 4'd0 || cursor_y !== 4'd0 || current_orientation !== 1'b0) begin
      fails++;
      $display("FAIL clear_to_aim: got len=%0d idx=%0d busy=%0d cur=(%0d,%0d) o=%0d required 5 0 0 (0,0) 0",
               current_ship_length, ship_idx, busy, cursor_x, cursor_y, current_orientation);
    end
  endtask

  task automatic test_move();
    press(3, 9);
    tests++;
    if (cursor_x !== 4'd5) begin
      fails++;
      $display("FAIL right_saturate: got x=%0d required 5", cursor_x);
    end
    press(4, 1);
    tests++;
    if (current_orientation !== 1'b1 || cursor_x !== 4'd5 || cursor_y !== 4'd0) begin
      fails++;
      $display("FAIL rotate_vert: got o=%0d (%0d,%0d) required 1 (5,0)", current_orientation, cursor_x, cursor_y);
    end
    press(1, 9);
    tests++;
    if (cursor_y !== 4'd5) begin
      fails++;
      $display("FAIL down_saturate: got y=%0d required 5", cursor_y);
    end
    press(3, 9);
    tests++;
    if (cursor_x !== 4'd9) begin
      fails++;
      $display("FAIL vert_right_limit: got x=%0d required 9", cursor_x);
    end
    press(4, 1);
    tests++;
    if (current_orientation !== 1'b0 || cursor_x !== 4'd5 || cursor_y !== 4'd5) begin
      fails++;
      $display("FAIL rotate_clamp: got o=%0d (%0d,%0d) required 0 (5,5)", current_orientation, cursor_x, cursor_y);
    end
    press(0, 5);
    press(2, 6);
    tests++;
    if (cursor_x !== 4'd0 || cursor_y !== 4'd0) begin
      fails++;
      $display("FAIL left_up_saturate: got (%0d,%0d) required (0,0)", cursor_x, cursor_y);
    end
  endtask

  task automatic test_place();
    int lat, nwr, werr;
    do_place(0, 0, 1'b0, lat, nwr, werr);
    tests++;
    if (lat != 5 || nwr != 5 || werr != 0) begin
      fails++;
      $display("FAIL place_ship0: got lat=%0d writes=%0d bad=%0d required 5 5 0", lat, nwr, werr);
    end
    tests++;
    if (ship_idx !== 3'd1 || current_ship_length !== 4'd4 || cursor_x !== 4'd0 ||
        cursor_y !== 4'd0 || current_orientation !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL next_ship1: got idx=%0d len=%0d (%0d,%0d) o=%0d busy=%0d required 1 4 (0,0) 0 0",
               ship_idx, current_ship_length, cursor_x, cursor_y, current_orientation, busy);
    end
  endtask

  task automatic test_reject();
    int nrej = 0;
    int nwr = 0;
    press(3, 2);
    press(4, 1);
    press(5, 1);
    for (int i = 0; i < 8; i++) begin
      step();
      if (reject === 1'b1) nrej++;
      if (wr_en === 1'b1) nwr++;
    end
    tests++;
    if (nrej != 1 || nwr != 0) begin
      fails++;
      $display("FAIL reject_pulse: got rejects=%0d writes=%0d required 1 0", nrej, nwr);
    end
    tests++;
    if (cursor_x !== 4'd2 || cursor_y !== 4'd0 || current_orientation !== 1'b1 ||
        current_ship_length !== 4'd4 || ship_idx !== 3'd1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reject_aim: got (%0d,%0d) o=%0d len=%0d idx=%0d busy=%0d required (2,0) 1 4 1 0",
               cursor_x, cursor_y, current_orientation, current_ship_length, ship_idx, busy);
    end
  endtask

  task automatic test_priority();
    int lat = 2;
    int nwr = 0;
    int werr = 0;
    press(3, 4);
    btn_place = 1'b1;
    btn_right = 1'b1;
    step();
    clear_btns();
    tests++;
    if (cursor_x !== 4'd6 || busy !== 1'b1) begin
      fails++;
      $display("FAIL place_priority: got x=%0d busy=%0d required 6 1", cursor_x, busy);
    end
    press(3, 1);
    btn_down = 1'b1;
    btn_rotate = 1'b1;
    step();
    clear_btns();
    tests++;
    if (cursor_x !== 4'd6 || cursor_y !== 4'd0 || current_orientation !== 1'b1) begin
      fails++;
      $display("FAIL check_ignores_btns: got (%0d,%0d) o=%0d required (6,0) 1", cursor_x, cursor_y, current_orientation);
    end
    while (wr_en !== 1'b1 && lat < 40) begin step(); lat++; end
    while (wr_en === 1'b1 && nwr < 40) begin
      if (wr_x !== 4'd6 || wr_y !== 4'(nwr) || wr_cell !== 3'(SHIP) || cursor_x !== 4'd6) werr++;
      nwr++;
      btn_left = 1'b1;
      btn_up = 1'b1;
      step();
      clear_btns();
    end
    step();
    tests++;
    if (lat != 4 || nwr != 4 || werr != 0) begin
      fails++;
      $display("FAIL place_ship1: got lat=%0d writes=%0d bad=%0d required 4 4 0", lat, nwr, werr);
    end
    tests++;
    if (ship_idx !== 3'd2 || current_ship_length !== 4'd3 || cursor_x !== 4'd0 || cursor_y !== 4'd0) begin
      fails++;
      $display("FAIL next_ship2: got idx=%0d len=%0d (%0d,%0d) required 2 3 (0,0)",
               ship_idx, current_ship_length, cursor_x, cursor_y);
    end
  endtask

  task automatic test_fleet();
    int lat, nwr, werr;
    int nship = 0;
    int exp_len [3] = '{3, 3, 2};
    for (int s = 0; s < 3; s++) begin
      do_place(0, s + 1, 1'b0, lat, nwr, werr);
      tests++;
      if (lat != exp_len[s] || nwr != exp_len[s] || werr != 0) begin
        fails++;
        $display("FAIL place_ship%0d: got lat=%0d writes=%0d bad=%0d required %0d %0d 0",
                 s + 2, lat, nwr, werr, exp_len[s], exp_len[s]);
      end
    end
    tests++;
    if (done !== 1'b1 || busy !== 1'b0 || current_ship_length !== 4'd0 || ship_idx !== 3'd4) begin
      fails++;
      $display("FAIL fleet_done: got done=%0d busy=%0d len=%0d idx=%0d required 1 0 0 4",
               done, busy, current_ship_length, ship_idx);
    end
    for (int y = 0; y < 10; y++)
      for (int x = 0; x < 10; x++)
        if (board_m[y][x] == 3'(SHIP)) nship++;
    tests++;
    if (nship != 17) begin
      fails++;
      $display("FAIL ship_cells: got %0d required 17", nship);
    end
    press(3, 2);
    press(5, 1);
    tests++;
    if (cursor_x !== 4'd0 || cursor_y !== 4'd3 || done !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL done_ignores_btns: got (%0d,%0d) done=%0d busy=%0d required (0,3) 1 0",
               cursor_x, cursor_y, done, busy);
    end
  endtask

  task automatic test_reset_mid_write();
    int n = 0;
    int nwr = 0;
    press(6, 1);
    tests++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL restart_from_done: got done=%0d busy=%0d required 0 1", done, busy);
    end
    while (busy === 1'b1 && n < 200) begin step(); n++; end
    press(5, 1);
    n = 0;
    while (wr_en !== 1'b1 && n < 40) begin step(); n++; end
    step(); step();
    tests++;
    if (wr_en !== 1'b1) begin
      fails++;
      $display("FAIL mid_write_setup: got wr_en=%0d required 1", wr_en);
    end
    reset = 1'b1;
    step();
    tests++;
    if (wr_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || current_ship_length !== 4'd0) begin
      fails++;
      $display("FAIL reset_abort: got wr_en=%0d busy=%0d done=%0d len=%0d required 0 0 0 0",
               wr_en, busy, done, current_ship_length);
    end
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (wr_en === 1'b1) nwr++;
    end
    tests++;
    if (nwr != 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL post_reset_idle: got writes=%0d busy=%0d required 0 0", nwr, busy);
    end
  endtask

  initial begin
    reset = 1'b1;
    clear_btns();
    test_reset();
    test_clear();
    test_move();
    test_place();
    test_reject();
    test_priority();
    test_fleet();
    test_reset_mid_write();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
